// File: rtl/wm8960_pkg.sv
// Shared types and constants for the WM8960 codec configuration sequencer.
package wm8960_pkg;

    localparam int unsigned C_REG_ADDR_WIDTH = 7;
    localparam int unsigned C_REG_DATA_WIDTH = 9;
    localparam logic [2:0]  C_ACK_ALL        = 3'b111;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT_LOAD,
        S_ISSUE,
        S_WAIT,
        S_USER_IDLE
    } state_t;

    typedef struct packed {
        logic [C_REG_ADDR_WIDTH-1:0] addr;
        logic [C_REG_DATA_WIDTH-1:0] data;
    } wm8960_cmd_t;

endpackage

// File: rtl/wm8960_init_rom.sv
// Codec bring-up table: soft reset, power management, then I2S/DAC/output routing.
module wm8960_init_rom
    import wm8960_pkg::*;
(
    input  logic [5:0]  index,
    output wm8960_cmd_t cmd
);

    always_comb begin
        cmd = '{addr: 7'h00, data: 9'h000};
        case (index)
            6'd0:    cmd = '{addr: 7'h0F, data: 9'h000};
            6'd1:    cmd = '{addr: 7'h19, data: 9'h0C0};
            6'd2:    cmd = '{addr: 7'h1A, data: 9'h1F8};
            6'd3:    cmd = '{addr: 7'h2F, data: 9'h00C};
            6'd4:    cmd = '{addr: 7'h04, data: 9'h000};
            6'd5:    cmd = '{addr: 7'h07, data: 9'h002};
            6'd6:    cmd = '{addr: 7'h05, data: 9'h000};
            6'd7:    cmd = '{addr: 7'h22, data: 9'h100};
            6'd8:    cmd = '{addr: 7'h25, data: 9'h100};
            6'd9:    cmd = '{addr: 7'h02, data: 9'h179};
            6'd10:   cmd = '{addr: 7'h03, data: 9'h179};
            6'd11:   cmd = '{addr: 7'h0A, data: 9'h1FF};
            6'd12:   cmd = '{addr: 7'h0B, data: 9'h1FF};
            6'd13:   cmd = '{addr: 7'h28, data: 9'h179};
            6'd14:   cmd = '{addr: 7'h29, data: 9'h179};
            6'd15:   cmd = '{addr: 7'h31, data: 9'h0F7};
            default: cmd = '{addr: 7'h00, data: 9'h000};
        endcase
    end

endmodule

// File: rtl/wm8960_config_sequencer.sv
// Power-up wait, init-table write-out and runtime register writes with NACK retry.
// Optional shadow readback register file: define WM8960_SHADOW_READBACK_EN.
module wm8960_config_sequencer
    import wm8960_pkg::*;
#(
    parameter logic [6:0]  G_DEVICE_ADDRESS = 7'h1A,
    parameter int unsigned G_NUM_INIT_WORDS = 16,
    parameter int unsigned G_POWERUP_DELAY  = 1000,
    parameter int unsigned G_MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    output logic       i2c_enable,
    output logic [6:0] i2c_device_address,
    output logic       i2c_rd_wr,
    output logic [6:0] i2c_register_address,
    output logic [8:0] i2c_register_data,
    output logic       i2c_valid,
    input  logic       i2c_ready,
    input  logic [2:0] i2c_acks_received,
    input  logic       i2c_done_valid,
    output logic       i2c_done_ready,
    input  logic [6:0] usr_register_address,
    input  logic [8:0] usr_register_data,
    input  logic       usr_valid,
    output logic       usr_ready,
    output logic       usr_done,
    output logic       usr_nack,
    output logic       init_done,
    output logic       init_error,
`ifdef WM8960_SHADOW_READBACK_EN
    output logic [7:0] error_count,
    input  logic [6:0] shadow_rd_address,
    output logic [8:0] shadow_rd_data,
    output logic       shadow_rd_valid
`else
    output logic [7:0] error_count
`endif
);

    localparam int unsigned PWR_W = (G_POWERUP_DELAY > 1) ? $clog2(G_POWERUP_DELAY) : 1;

    state_t            state_q, state_d;
    logic [PWR_W-1:0]  pwr_cnt_q;
    logic [5:0]        init_index_q;
    logic [3:0]        retry_cnt_q;
    wm8960_cmd_t       cmd_q, rom_cmd;
    logic              enable_q, usr_done_q, usr_nack_q, init_done_q, init_error_q;
    logic [7:0]        error_count_q;
    logic              ack_ok, retry_ok, last_entry, pwr_done, done_evt;

    wm8960_init_rom u_init_rom (
        .index (init_index_q),
        .cmd   (rom_cmd)
    );

    assign done_evt   = (state_q == S_WAIT) && i2c_done_valid;
    assign ack_ok     = (i2c_acks_received == C_ACK_ALL);
    assign retry_ok   = (retry_cnt_q < 4'(G_MAX_RETRIES));
    assign last_entry = (init_index_q == 6'(G_NUM_INIT_WORDS - 1));
    assign pwr_done   = (pwr_cnt_q == PWR_W'(G_POWERUP_DELAY - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_POWERUP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_POWERUP:   if (pwr_done) state_d = S_INIT_LOAD;
            S_INIT_LOAD: state_d = S_ISSUE;
            S_ISSUE:     if (i2c_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (i2c_done_valid) begin
                    if (!ack_ok && retry_ok)            state_d = S_ISSUE;
                    else if (init_done_q || last_entry) state_d = S_USER_IDLE;
                    else                                state_d = S_INIT_LOAD;
                end
            end
            S_USER_IDLE: if (usr_valid) state_d = S_ISSUE;
            default:     state_d = S_POWERUP;
        endcase
    end

    always_comb begin
        i2c_valid = (state_q == S_ISSUE);
        usr_ready = (state_q == S_USER_IDLE);
    end

    // Command latch, retry bookkeeping and sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q      <= 1'b0;
            pwr_cnt_q     <= '0;
            init_index_q  <= '0;
            retry_cnt_q   <= '0;
            cmd_q         <= '{addr: 7'h00, data: 9'h000};
            usr_done_q    <= 1'b0;
            usr_nack_q    <= 1'b0;
            init_done_q   <= 1'b0;
            init_error_q  <= 1'b0;
            error_count_q <= '0;
        end else begin
            enable_q   <= 1'b1;
            usr_done_q <= 1'b0;
            usr_nack_q <= 1'b0;
            case (state_q)
                S_POWERUP: pwr_cnt_q <= pwr_cnt_q + PWR_W'(1);
                S_INIT_LOAD: begin
                    cmd_q       <= rom_cmd;
                    retry_cnt_q <= '0;
                end
                S_USER_IDLE: begin
                    if (usr_valid) begin
                        cmd_q       <= '{addr: usr_register_address, data: usr_register_data};
                        retry_cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (i2c_done_valid) begin
                        if (!ack_ok && retry_ok) begin
                            retry_cnt_q <= retry_cnt_q + 4'd1;
                        end else begin
                            if (!ack_ok && (error_count_q != 8'hFF)) begin
                                error_count_q <= error_count_q + 8'd1;
                            end
                            if (init_done_q) begin
                                usr_done_q <= 1'b1;
                                usr_nack_q <= !ack_ok;
                            end else begin
                                if (!ack_ok) init_error_q <= 1'b1;
                                if (last_entry) init_done_q  <= 1'b1;
                                else            init_index_q <= init_index_q + 6'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_enable           = enable_q;
    assign i2c_done_ready       = enable_q;
    assign i2c_device_address   = G_DEVICE_ADDRESS;
    assign i2c_rd_wr            = 1'b0;
    assign i2c_register_address = cmd_q.addr;
    assign i2c_register_data    = cmd_q.data;
    assign usr_done             = usr_done_q;
    assign usr_nack             = usr_nack_q;
    assign init_done            = init_done_q;
    assign init_error           = init_error_q;
    assign error_count          = error_count_q;

`ifdef WM8960_SHADOW_READBACK_EN
    // The codec is write-only, so this mirror is the only way to read settings back.
    logic [8:0] shadow_q [128];
    logic [8:0] shadow_rd_data_q;
    logic       shadow_rd_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) shadow_q[i] <= '0;
            shadow_rd_data_q  <= '0;
            shadow_rd_valid_q <= 1'b0;
        end else begin
            if (done_evt && ack_ok) shadow_q[cmd_q.addr] <= cmd_q.data;
            shadow_rd_data_q  <= shadow_q[shadow_rd_address];
            shadow_rd_valid_q <= 1'b1;
        end
    end

    assign shadow_rd_data  = shadow_rd_data_q;
    assign shadow_rd_valid = shadow_rd_valid_q;
`endif

endmodule

// File: tb/tb_wm8960_config_sequencer.sv
// Self-checking bench: randomized I2C slave responder plus a transaction-level reference model.
module tb_wm8960_config_sequencer;

    localparam int unsigned D   = 20;
    localparam int unsigned N   = 16;
    localparam int unsigned MAX = 3;

    typedef struct {
        int nack_entry;
        int nack_times;
        bit rnd;
        bit exp_ierr;
        int exp_err;
    } init_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i2c_enable, i2c_rd_wr, i2c_valid, i2c_ready, i2c_done_valid, i2c_done_ready;
    logic [6:0] i2c_device_address, i2c_register_address;
    logic [8:0] i2c_register_data;
    logic [2:0] i2c_acks_received;
    logic [6:0] usr_register_address = '0;
    logic [8:0] usr_register_data = '0;
    logic       usr_valid = 1'b0;
    logic       usr_ready, usr_done, usr_nack, init_done, init_error;
    logic [7:0] error_count;
`ifdef WM8960_SHADOW_READBACK_EN
    logic [6:0] shadow_rd_address = '0;
    logic [8:0] shadow_rd_data;
    logic       shadow_rd_valid;
`endif

    always #5 clk = ~clk;

    wm8960_config_sequencer #(
        .G_DEVICE_ADDRESS (7'h1A),
        .G_NUM_INIT_WORDS (N),
        .G_POWERUP_DELAY  (D),
        .G_MAX_RETRIES    (MAX)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .i2c_enable           (i2c_enable),
        .i2c_device_address   (i2c_device_address),
        .i2c_rd_wr            (i2c_rd_wr),
        .i2c_register_address (i2c_register_address),
        .i2c_register_data    (i2c_register_data),
        .i2c_valid            (i2c_valid),
        .i2c_ready            (i2c_ready),
        .i2c_acks_received    (i2c_acks_received),
        .i2c_done_valid       (i2c_done_valid),
        .i2c_done_ready       (i2c_done_ready),
        .usr_register_address (usr_register_address),
        .usr_register_data    (usr_register_data),
        .usr_valid            (usr_valid),
        .usr_ready            (usr_ready),
        .usr_done             (usr_done),
        .usr_nack             (usr_nack),
        .init_done            (init_done),
        .init_error           (init_error),
`ifdef WM8960_SHADOW_READBACK_EN
        .error_count          (error_count),
        .shadow_rd_address    (shadow_rd_address),
        .shadow_rd_data       (shadow_rd_data),
        .shadow_rd_valid      (shadow_rd_valid)
`else
        .error_count          (error_count)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] obs_q[$];
    logic [2:0]  ack_plan[$];
    bit          hold_done = 1'b0;
    int          overlap_cnt = 0;
    logic [8:0]  shadow_m [128];
    int          exp_errcnt = 0;

    function automatic logic [15:0] rom_exp(input int i);
        case (i)
            0:  return {7'h0F, 9'h000};
            1:  return {7'h19, 9'h0C0};
            2:  return {7'h1A, 9'h1F8};
            3:  return {7'h2F, 9'h00C};
            4:  return {7'h04, 9'h000};
            5:  return {7'h07, 9'h002};
            6:  return {7'h05, 9'h000};
            7:  return {7'h22, 9'h100};
            8:  return {7'h25, 9'h100};
            9:  return {7'h02, 9'h179};
            10: return {7'h03, 9'h179};
            11: return {7'h0A, 9'h1FF};
            12: return {7'h0B, 9'h1FF};
            13: return {7'h28, 9'h179};
            14: return {7'h29, 9'h179};
            15: return {7'h31, 9'h0F7};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // I2C master stand-in: random ready, random completion latency, acks from ack_plan.
    initial begin : responder
        bit          pending = 1'b0;
        bit          acc_prev = 1'b0;
        int          lat = 0;
        logic [15:0] cmd_prev = '0;
        i2c_ready = 1'b0;
        i2c_done_valid = 1'b0;
        i2c_acks_received = 3'b000;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                pending = 1'b0;
                acc_prev = 1'b0;
                i2c_ready = 1'b0;
                i2c_done_valid = 1'b0;
            end else begin
                if (acc_prev) begin
                    if (pending) overlap_cnt++;
                    obs_q.push_back(cmd_prev);
                    pending = 1'b1;
                    lat = $urandom_range(0, 3);
                end
                i2c_done_valid = 1'b0;
                if (pending) begin
                    if (!hold_done) begin
                        if (lat == 0) begin
                            i2c_done_valid = 1'b1;
                            if (ack_plan.size() > 0) i2c_acks_received = ack_plan.pop_front();
                            else                     i2c_acks_received = 3'b111;
                            pending = 1'b0;
                        end else begin
                            lat--;
                        end
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    // stray completion with a NACK pattern; must be ignored
                    i2c_done_valid = 1'b1;
                    i2c_acks_received = 3'($urandom_range(0, 6));
                end
                i2c_ready = ($urandom_range(0, 2) != 0);
                acc_prev = i2c_valid && i2c_ready;
                cmd_prev = {i2c_register_address, i2c_register_data};
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic apply_reset(input bit check_outputs);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        obs_q.delete();
        ack_plan.delete();
        for (int i = 0; i < 128; i++) shadow_m[i] = '0;
        exp_errcnt = 0;
        if (check_outputs) begin
            check("rst_i2c_enable", i2c_enable, 0);
            check("rst_i2c_valid", i2c_valid, 0);
            check("rst_i2c_done_ready", i2c_done_ready, 0);
            check("rst_usr_ready", usr_ready, 0);
            check("rst_usr_done", usr_done, 0);
            check("rst_usr_nack", usr_nack, 0);
            check("rst_init_done", init_done, 0);
            check("rst_init_error", init_error, 0);
            check("rst_error_count", error_count, 0);
            check("rst_reg_addr", i2c_register_address, 0);
            check("rst_reg_data", i2c_register_data, 0);
        end
    endtask

    // First command appears after the power-up count plus one ROM load cycle.
    task automatic release_reset();
        int k;
        reset = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!i2c_valid && k < int'(D) + 50);
        check("powerup_latency", k, D + 1);
        check("enable_after_reset", i2c_enable, 1);
        check("done_ready_after_reset", i2c_done_ready, 1);
    endtask

    task automatic wait_init_done();
        int cyc;
        cyc = 0;
        while (!init_done && cyc < 4000) begin
            tick();
            cyc++;
        end
        check("init_done", init_done, 1);
    endtask

    task automatic run_init(input init_vec_t v, input bit first);
        int          k, iss, mexp_err, bad;
        bit          mexp_ierr;
        logic [15:0] exp_cmds[$];
        logic [15:0] rc;
        apply_reset(first);
        mexp_err = 0;
        mexp_ierr = 1'b0;
        for (int e = 0; e < int'(N); e++) begin
            rc = rom_exp(e);
            if (v.rnd) k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX + 1)) : 0;
            else       k = (e == v.nack_entry) ? v.nack_times : 0;
            iss = (k > int'(MAX)) ? int'(MAX) + 1 : k + 1;
            for (int a = 0; a < iss; a++) begin
                exp_cmds.push_back(rc);
                if (a < k) ack_plan.push_back(3'($urandom_range(0, 6)));
                else       ack_plan.push_back(3'b111);
            end
            if (k > int'(MAX)) begin
                mexp_err++;
                mexp_ierr = 1'b1;
            end else begin
                shadow_m[rc[15:9]] = rc[8:0];
            end
        end
        release_reset();
        wait_init_done();
        check("init_cmd_count", obs_q.size(), exp_cmds.size());
        bad = -1;
        for (int i = 0; i < obs_q.size() && i < exp_cmds.size(); i++)
            if (obs_q[i] !== exp_cmds[i] && bad < 0) bad = i;
        check("init_cmd_order_first_bad_index", bad, -1);
        check("ack_plan_consumed", ack_plan.size(), 0);
        if (v.rnd) begin
            check("init_error_rnd", init_error, mexp_ierr);
            check("error_count_rnd", error_count, mexp_err);
            exp_errcnt = mexp_err;
        end else begin
            check("init_error", init_error, v.exp_ierr);
            check("error_count", error_count, v.exp_err);
            exp_errcnt = v.exp_err;
        end
    endtask

    task automatic usr_write(input logic [6:0] a, input logic [8:0] d, input int k,
                             input bit detail);
        int iss, base, cyc, early, bad;
        bit exp_nack;
        iss = (k > int'(MAX)) ? int'(MAX) + 1 : k + 1;
        exp_nack = (k > int'(MAX));
        for (int i = 0; i < iss; i++)
            ack_plan.push_back((i < k) ? 3'($urandom_range(0, 6)) : 3'b111);
        usr_register_address = a;
        usr_register_data = d;
        usr_valid = 1'b1;
        cyc = 0;
        early = 0;
        while (!usr_ready && cyc < 4000) begin
            tick();
            cyc++;
            if (usr_ready && !init_done) early++;
        end
        tick();
        usr_valid = 1'b0;
        base = obs_q.size();
        if (detail) begin
            check("usr_ready_held_during_init", early, 0);
            check("usr_ready_drops_after_hs", usr_ready, 0);
            check("usr_to_i2c_valid_latency", i2c_valid, 1);
            check("usr_cmd_addr", i2c_register_address, a);
            check("usr_cmd_data", i2c_register_data, d);
        end
        cyc = 0;
        while (!usr_done && cyc < 500) begin
            tick();
            cyc++;
        end
        check("usr_done", usr_done, 1);
        check("usr_nack", usr_nack, exp_nack);
        check("usr_issue_count", obs_q.size() - base, iss);
        bad = -1;
        for (int i = base; i < obs_q.size(); i++)
            if (obs_q[i] !== {a, d} && bad < 0) bad = i - base;
        check("usr_issue_content_first_bad", bad, -1);
        if (exp_nack) exp_errcnt = (exp_errcnt < 255) ? exp_errcnt + 1 : 255;
        else          shadow_m[a] = d;
        check("usr_error_count", error_count, exp_errcnt);
        if (detail) begin
            tick();
            check("usr_done_one_cycle", usr_done, 0);
        end
`ifdef WM8960_SHADOW_READBACK_EN
        shadow_rd_address = a;
        tick();
        check("shadow_rd_valid", shadow_rd_valid, 1);
        check("shadow_rd_data_written", shadow_rd_data, shadow_m[a]);
        shadow_rd_address = 7'($urandom_range(0, 127));
        tick();
        check("shadow_rd_data_random", shadow_rd_data, shadow_m[shadow_rd_address]);
`endif
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        init_vec_t vecs[5];
        int        cyc, base;
        vecs[0] = '{nack_entry: -1, nack_times: 0, rnd: 1'b0, exp_ierr: 1'b0, exp_err: 0};
        vecs[1] = '{nack_entry: 2,  nack_times: 2, rnd: 1'b0, exp_ierr: 1'b0, exp_err: 0};
        vecs[2] = '{nack_entry: 4,  nack_times: 4, rnd: 1'b0, exp_ierr: 1'b1, exp_err: 1};
        vecs[3] = '{nack_entry: 15, nack_times: 4, rnd: 1'b0, exp_ierr: 1'b1, exp_err: 1};
        vecs[4] = '{nack_entry: -1, nack_times: 0, rnd: 1'b1, exp_ierr: 1'b0, exp_err: 0};

        for (int r = 0; r < 5; r++) run_init(vecs[r], r == 0);
        check("device_address", i2c_device_address, 7'h1A);
        check("rd_wr", i2c_rd_wr, 0);

        // User write issued while init is still running must be held off, not dropped.
        apply_reset(1'b0);
        for (int e = 0; e < int'(N); e++) shadow_m[rom_exp(e) >> 9] = rom_exp(e) & 16'h01FF;
        release_reset();
        usr_write(7'h07, 9'h00A, 0, 1'b1);
        check("init_error_clean", init_error, 0);
        usr_write(7'h07, 9'h1FF, MAX + 1, 1'b1);
        usr_write(7'h0B, 9'h0F0, MAX, 1'b1);
        for (int i = 0; i < 20; i++)
            usr_write(7'($urandom_range(0, 127)), 9'($urandom_range(0, 511)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, MAX + 1)) : 0, 1'b0);
        for (int i = 0; i < 256; i++)
            usr_write(7'($urandom_range(0, 127)), 9'($urandom_range(0, 511)), MAX + 1, 1'b0);
        check("error_count_saturated", error_count, 255);
        usr_write(7'h7F, 9'h155, 0, 1'b0);

        // Reset while a transaction is outstanding.
        hold_done = 1'b1;
        usr_register_address = 7'h10;
        usr_register_data = 9'h0AA;
        usr_valid = 1'b1;
        cyc = 0;
        while (!usr_ready && cyc < 100) begin tick(); cyc++; end
        base = obs_q.size();
        tick();
        usr_valid = 1'b0;
        cyc = 0;
        while (obs_q.size() == base && cyc < 100) begin tick(); cyc++; end
        check("wait_cmd_accepted", obs_q.size(), base + 1);
        check("in_wait_valid_low", i2c_valid, 0);
        reset = 1'b1;
        tick();
        check("midrst_i2c_enable", i2c_enable, 0);
        check("midrst_i2c_valid", i2c_valid, 0);
        check("midrst_done_ready", i2c_done_ready, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_error_count", error_count, 0);
        hold_done = 1'b0;
        repeat (2) tick();
        obs_q.delete();
        ack_plan.delete();
        release_reset();
        check("restart_first_addr", i2c_register_address, 7'h0F);
        check("restart_first_data", i2c_register_data, 9'h000);
`ifdef WM8960_SHADOW_READBACK_EN
        shadow_rd_address = 7'h7F;
        tick();
        check("shadow_cleared_by_reset", shadow_rd_data, 0);
`endif
        wait_init_done();
        check("restart_cmd_count", obs_q.size(), N);
        check("no_overlapping_transactions", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wm8960_config_sequencer.md
Name: wm8960_config_sequencer

Overview:
- Drives the command side of the WM8960 I2C master and sequences codec configuration.
- After reset it waits out a power-up delay, then writes an init table of register/data pairs from sub-module wm8960_init_rom.
- It then accepts runtime single-register writes from one user port, and retries NACKed transactions.
- Sits between the I2C master and the audio control logic.

Parameters:
- G_DEVICE_ADDRESS, 7'h1A, 7-bit I2C address of the codec.
- G_NUM_INIT_WORDS, 16, number of init table entries (1..64).
- G_POWERUP_DELAY, 1000, clk cycles to wait before the first transaction (>=1).
- G_MAX_RETRIES, 3, re-issues allowed per transaction after a NACK (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i2c_enable  out  1  enable to the I2C master; 0 during reset, 1 afterwards.
- i2c_device_address  out  7  always G_DEVICE_ADDRESS.
- i2c_rd_wr  out  1  always 0 (write).
- i2c_register_address  out  7  register address of the current command.
- i2c_register_data  out  9  register data of the current command.
- i2c_valid  out  1  command valid.
- i2c_ready  in  1  master accepts a command.
- i2c_acks_received  in  3  ack bits of the completed transaction.
- i2c_done_valid  in  1  transaction complete.
- i2c_done_ready  out  1  always 1 when not in reset.
- usr_register_address  in  7  runtime write address.
- usr_register_data  in  9  runtime write data.
- usr_valid  in  1  runtime write request.
- usr_ready  out  1  request accepted when valid&ready.
- usr_done  out  1  one-cycle pulse when the runtime write finishes.
- usr_nack  out  1  qualifies usr_done: the write failed after all retries.
- init_done  out  1  sticky; init table completed.
- init_error  out  1  sticky; at least one init entry failed after all retries.
- error_count  out  8  saturating count of failed transactions.

Behaviour:
Reset values:
- All outputs 0.
- Counters cleared; state S_POWERUP.
- Reset mid-transaction abandons it; i2c_enable=0 resets the master.

States:
- S_POWERUP: count G_POWERUP_DELAY cycles, then go to S_INIT_LOAD.
- S_INIT_LOAD: read the ROM at init_index (combinational), latch the address/data into the command registers, retry_cnt=0, go to S_ISSUE.
- S_ISSUE: i2c_valid=1 with stable outputs. On i2c_valid&i2c_ready (same edge), i2c_valid<=0 and go to S_WAIT.
- S_WAIT: wait for i2c_done_valid.
  - Success is acks==3'b111.
  - On failure with retry_cnt<G_MAX_RETRIES: increment retry_cnt and go back to S_ISSUE with the same command.
  - On failure with retries exhausted: error_count increments, saturating at 255.
  - Init phase: a failure sets init_error and the sequence continues. After completion, init_index increments. When init_index==G_NUM_INIT_WORDS-1 completes, set init_done and go to S_USER_IDLE; otherwise go to S_INIT_LOAD.
  - User phase: usr_done=1 for one cycle, usr_nack=failure, then go to S_USER_IDLE.
- S_USER_IDLE: usr_ready=1 only in this state. On usr_valid&usr_ready, latch the request, retry_cnt=0, usr_ready<=0, go to S_ISSUE.
- usr_valid before init_done is held off (usr_ready stays 0); it is not dropped.

Other rules:
- Only one transaction is in flight at a time; nothing new is issued until i2c_done_valid.
- i2c_done_valid arriving outside S_WAIT is ignored.
- Latency from a usr handshake to i2c_valid is 1 cycle.

Optional Feature:
Macro WM8960_SHADOW_READBACK_EN.
- With it defined:
  - Add a 128x9 shadow register file, updated on every successful write (init and user).
  - Add ports shadow_rd_address in 7, shadow_rd_data out 9, and shadow_rd_valid out 1.
  - shadow_rd_valid/shadow_rd_data appear 1 cycle after the address is presented. The WM8960 is write-only over I2C, so the shadow is the only readback path.
  - Reset clears all entries to 0.
- Without it: no storage and no extra ports.

Decomposition:
- Package wm8960_pkg holds:
  - state_t enum;
  - C_REG_ADDR_WIDTH=7, C_REG_DATA_WIDTH=9, C_ACK_ALL=3'b111;
  - the struct wm8960_cmd_t {addr[6:0], data[8:0]}.
- Sub-module wm8960_init_rom is a combinational case statement, index[5:0] -> wm8960_cmd_t. Its default table starts with reset (0x0F, 0x000), then power management registers 0x19, 0x1A, 0x2F.

Test Plan:
- Reset, all slave acks -> G_POWERUP_DELAY idle cycles, then 16 transactions in ROM order, first being addr 0x0F data 0x000. init_done=1, init_error=0, error_count=0.
- NACK the 3rd init transaction twice, then ack -> the same command is issued 3 times, the sequence continues, init_error=0.
- NACK the 5th entry 4 times (G_MAX_RETRIES=3) -> 4 issues, init_error=1, error_count=1, the 6th entry follows.
- After init, usr write 0x07/0x00A -> usr_ready drops, one command with those values, usr_done pulse with usr_nack=0. usr_valid asserted during init waits until init_done.
- Assert reset while in S_WAIT -> i2c_enable=0 and i2c_valid=0 next cycle; after release the power-up delay restarts and init_index=0.
- With WM8960_SHADOW_READBACK_EN: after the user write 0x07/0x00A, read address 0x07 -> 0x00A one cycle later. A failed write leaves the shadow unchanged.
